// File: rtl/irq_pending_if.sv
// Request, mask, clear and offer-handshake signals between the pending-capture
// stage and its producer/consumer side.
interface irq_pending_if #(
    parameter int IN_WIDTH = 4
);
    localparam int OUT_WIDTH = $clog2(IN_WIDTH);

    logic [IN_WIDTH-1:0]  req_i;
    logic [IN_WIDTH-1:0]  mask_i;
    logic [IN_WIDTH-1:0]  clr_i;
    logic [IN_WIDTH-1:0]  pend_o;
    logic                 irq_valid_o;
    logic                 irq_ready_i;
    logic [OUT_WIDTH-1:0] irq_id_o;

    modport slave (
        input  req_i, mask_i, clr_i, irq_ready_i,
        output pend_o, irq_valid_o, irq_id_o
    );

    modport master (
        output req_i, mask_i, clr_i, irq_ready_i,
        input  pend_o, irq_valid_o, irq_id_o
    );
endinterface

// File: rtl/irq_pending_ctrl.sv
// Sticky pending capture with per-bit mask, feeding the priority encoder and
// offering the highest active index over a valid/ready handshake.
//
// state | meaning
// IDLE  | no offer; picks the highest masked pending bit when one exists
// OFFER | irq_id_o/irq_valid_o held stable until the consumer accepts
// HOLD  | post-accept idle gap, counter runs down to zero
module irq_pending_ctrl #(
    parameter int IN_WIDTH = 4,
    parameter bit EDGE     = 1'b1,
    parameter int HOLDOFF  = 2
) (
    input  logic          clk,
    input  logic          rst,
    irq_pending_if.slave  bus
);
    localparam int OUT_WIDTH = $clog2(IN_WIDTH);
    localparam logic [7:0] HOLD_LOAD = (HOLDOFF > 0) ? 8'(HOLDOFF - 1) : 8'd0;

    typedef enum logic [1:0] {IDLE, OFFER, HOLD} state_t;

    state_t               state, state_nxt;
    logic [IN_WIDTH-1:0]  pending, pending_nxt;
    logic [IN_WIDTH-1:0]  pend_q;
    logic [IN_WIDTH-1:0]  set_vec;
    logic [IN_WIDTH-1:0]  acc_vec;
    logic [IN_WIDTH-1:0]  active;
    logic [OUT_WIDTH-1:0] winner;
    logic [OUT_WIDTH-1:0] id_q, id_nxt;
    logic                 valid_q, valid_nxt;
    logic [7:0]           cnt, cnt_nxt;

    generate
        if (EDGE) begin : g_edge
            logic [IN_WIDTH-1:0] req_d;
            // req_d follows req_i under reset so lines already high at release are not seen as edges
            always_ff @(posedge clk) begin
                req_d <= bus.req_i;
            end
            assign set_vec = bus.req_i & ~req_d;
        end else begin : g_level
            assign set_vec = bus.req_i;
        end
    endgenerate

    always_comb begin
        acc_vec = '0;
        if (valid_q && bus.irq_ready_i) begin
            acc_vec[id_q] = 1'b1;
        end
    end

    // set wins over a same-cycle clear or accept on the same bit
    assign pending_nxt = (pending & ~bus.clr_i & ~acc_vec) | set_vec;
    assign active      = pending & bus.mask_i;

    always_comb begin
        winner = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (active[i]) begin
                winner = OUT_WIDTH'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        valid_nxt = valid_q;
        id_nxt    = id_q;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (|active) begin
                    id_nxt    = winner;
                    valid_nxt = 1'b1;
                    state_nxt = OFFER;
                end
            end
            OFFER: begin
                if (bus.irq_ready_i) begin
                    valid_nxt = 1'b0;
                    if (HOLDOFF == 0) begin
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt   = HOLD_LOAD;
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (cnt == 8'd0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: begin
                valid_nxt = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pending <= '0;
            pend_q  <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            cnt     <= 8'd0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
            pend_q  <= pending_nxt & bus.mask_i;
            valid_q <= valid_nxt;
            id_q    <= id_nxt;
            cnt     <= cnt_nxt;
        end
    end

    assign bus.pend_o      = pend_q;
    assign bus.irq_valid_o = valid_q;
    assign bus.irq_id_o    = id_q;
endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl: edge-capture instance (HOLDOFF=2) and
// level-capture instance (HOLDOFF=0), offered ids checked against a queue.
module tb_irq_pending_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    irq_pending_if #(.IN_WIDTH(4)) ifa ();
    irq_pending_if #(.IN_WIDTH(4)) ifb ();

    irq_pending_ctrl #(.IN_WIDTH(4), .EDGE(1'b1), .HOLDOFF(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    irq_pending_ctrl #(.IN_WIDTH(4), .EDGE(1'b0), .HOLDOFF(0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // waits for an offer, then compares its id with the oldest expected id
    task automatic wait_offer(input bit sel, input int max, output int n);
        logic       v;
        logic [1:0] id;
        int         e;
        n = 0;
        v = sel ? ifb.irq_valid_o : ifa.irq_valid_o;
        while (v !== 1'b1 && n < max) begin
            tick();
            n++;
            v = sel ? ifb.irq_valid_o : ifa.irq_valid_o;
        end
        chk("offer_seen", 32'(v), 32'd1);
        if (v === 1'b1) begin
            id = sel ? ifb.irq_id_o : ifa.irq_id_o;
            e  = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            chk("offer_id", 32'(id), 32'(e));
        end
    endtask

    task automatic accept(input bit sel);
        if (sel) ifb.irq_ready_i = 1'b1;
        else     ifa.irq_ready_i = 1'b1;
        tick();
        ifa.irq_ready_i = 1'b0;
        ifb.irq_ready_i = 1'b0;
        chk("accept_drop", 32'(sel ? ifb.irq_valid_o : ifa.irq_valid_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        ifa.req_i = 4'hF; ifa.mask_i = 4'hF; ifa.clr_i = 4'h0; ifa.irq_ready_i = 1'b0;
        ifb.req_i = 4'h0; ifb.mask_i = 4'hF; ifb.clr_i = 4'h0; ifb.irq_ready_i = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_pend", 32'(ifa.pend_o), 32'h0);
        chk("rst_valid", 32'(ifa.irq_valid_o), 32'h0);
        chk("rst_id", 32'(ifa.irq_id_o), 32'h0);
        chk("rst_valid_b", 32'(ifb.irq_valid_o), 32'h0);

        rst = 1'b0;
        repeat (4) tick();
        chk("release_pend", 32'(ifa.pend_o), 32'h0);
        chk("release_valid", 32'(ifa.irq_valid_o), 32'h0);
        ifa.req_i = 4'h0;
        tick();

        // priority and latency
        exp_q.push_back(2);
        exp_q.push_back(0);
        ifa.req_i = 4'b0101;
        tick();
        chk("lat_pend", 32'(ifa.pend_o), 32'b0101);
        chk("lat_valid_early", 32'(ifa.irq_valid_o), 32'd0);
        ifa.req_i = 4'b0000;
        tick();
        chk("lat_valid", 32'(ifa.irq_valid_o), 32'd1);
        wait_offer(1'b0, 4, n);
        accept(1'b0);
        chk("prio_pend_1", 32'(ifa.pend_o), 32'b0001);
        wait_offer(1'b0, 8, n);
        chk("prio_holdoff", 32'(n), 32'd3);
        accept(1'b0);
        chk("prio_pend_0", 32'(ifa.pend_o), 32'b0000);

        // stall with no preemption
        repeat (3) tick();
        exp_q.push_back(1);
        ifa.req_i = 4'b0010;
        tick();
        ifa.req_i = 4'b0000;
        wait_offer(1'b0, 4, n);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                ifa.req_i = 4'b1000;
                exp_q.push_back(3);
            end
            if (i == 2) ifa.req_i = 4'b0000;
            tick();
            chk("stall_valid", 32'(ifa.irq_valid_o), 32'd1);
            chk("stall_id", 32'(ifa.irq_id_o), 32'd1);
        end
        chk("stall_pend", 32'(ifa.pend_o), 32'b1010);
        accept(1'b0);
        wait_offer(1'b0, 8, n);
        chk("stall_holdoff", 32'(n), 32'd3);
        accept(1'b0);

        // mask
        repeat (3) tick();
        ifa.mask_i = 4'b1101;
        ifa.req_i  = 4'b0010;
        tick();
        ifa.req_i = 4'b0000;
        repeat (4) tick();
        chk("mask_valid", 32'(ifa.irq_valid_o), 32'd0);
        chk("mask_pend", 32'(ifa.pend_o), 32'h0);
        exp_q.push_back(1);
        ifa.mask_i = 4'hF;
        tick();
        chk("unmask_pend", 32'(ifa.pend_o), 32'b0010);
        wait_offer(1'b0, 3, n);
        accept(1'b0);

        // set during accept of the same bit
        repeat (3) tick();
        exp_q.push_back(2);
        ifa.req_i = 4'b0100;
        tick();
        ifa.req_i = 4'b0000;
        wait_offer(1'b0, 4, n);
        ifa.req_i = 4'b0100;
        ifa.irq_ready_i = 1'b1;
        tick();
        ifa.req_i = 4'b0000;
        ifa.irq_ready_i = 1'b0;
        chk("coll_valid", 32'(ifa.irq_valid_o), 32'd0);
        chk("coll_pend", 32'(ifa.pend_o), 32'b0100);
        exp_q.push_back(2);
        wait_offer(1'b0, 8, n);
        chk("coll_holdoff", 32'(n), 32'd3);
        accept(1'b0);
        chk("coll_pend_0", 32'(ifa.pend_o), 32'h0);

        // software clear of a non-offered bit
        repeat (3) tick();
        exp_q.push_back(2);
        ifa.req_i = 4'b0100;
        tick();
        ifa.req_i = 4'b0000;
        wait_offer(1'b0, 4, n);
        ifa.req_i = 4'b1000;
        tick();
        ifa.req_i = 4'b0000;
        chk("clr_pend_before", 32'(ifa.pend_o), 32'b1100);
        chk("clr_id_held", 32'(ifa.irq_id_o), 32'd2);
        ifa.clr_i = 4'b1000;
        tick();
        ifa.clr_i = 4'b0000;
        chk("clr_pend_after", 32'(ifa.pend_o), 32'b0100);
        accept(1'b0);
        repeat (6) tick();
        chk("clr_no_offer", 32'(ifa.irq_valid_o), 32'd0);
        chk("clr_pend_0", 32'(ifa.pend_o), 32'h0);

        // level capture, req[0] held high
        for (int k = 0; k < 4; k++) exp_q.push_back(0);
        ifb.req_i = 4'b0001;
        tick();
        wait_offer(1'b1, 4, n);
        chk("lvl_first", 32'(n), 32'd1);
        for (int k = 0; k < 3; k++) begin
            accept(1'b1);
            chk("lvl_pend", 32'(ifb.pend_o), 32'b0001);
            wait_offer(1'b1, 4, n);
            chk("lvl_gap", 32'(n), 32'd1);
        end
        ifb.req_i = 4'b0000;
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
